// File: rtl/read_queue_pkg.sv
// Shared constants and helpers for the read_queue width-up packer.
package read_queue_pkg;

    localparam int IN_WIDTH_DEF  = 32;
    localparam int OUT_WIDTH_DEF = 512;

    typedef enum logic {
        PH_FILL,
        PH_LAST
    } phase_e;

    function automatic int words_per_beat(input int in_w, input int out_w);
        return out_w / in_w;
    endfunction

    // One spare bit so the count never has to rely on overflow to wrap.
    function automatic int cnt_width(input int max_words);
        return $clog2(max_words) + 1;
    endfunction

endpackage

// File: rtl/read_queue_rise_detect.sv
// Registered rising-edge detector: rise_o is high for the first cycle d_i reads high.
module rise_detect #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] rise_o
);

    logic [DATA_W-1:0] d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= '0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/read_queue.sv
// Width-up packer: IN_WIDTH words into OUT_WIDTH beats, word 0 in the low bits.
// Optional partial-beat flush port when READ_QUEUE_FLUSH_EN is defined.
module read_queue
    import read_queue_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 vld_in,
    output logic                 rdy_upward,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 vld_out,
    input  logic                 rdy_downward,
    input  logic                 ap_start
`ifdef READ_QUEUE_FLUSH_EN
    ,
    input  logic                 flush
`endif
);

    localparam int MAX   = words_per_beat(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W = cnt_width(MAX);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX - 1);

    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [MAX-2:0][IN_WIDTH-1:0]   acc_q, acc_d;
    logic [OUT_WIDTH-1:0]           dout_q, dout_d;
    logic                           vld_q, vld_d;
    logic                           clr;
    logic                           slot_blocked;
    logic                           in_fire;
    logic                           out_fire;
    logic                           flush_pend;
    logic                           flush_take;
    phase_e                         phase;

    rise_detect #(
        .DATA_W (1)
    ) u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (ap_start),
        .rise_o (clr)
    );

    assign phase        = (cnt_q == LAST_IDX) ? PH_LAST : PH_FILL;
    assign slot_blocked = vld_q && !rdy_downward;

`ifdef READ_QUEUE_FLUSH_EN
    assign flush_pend = flush && (cnt_q != '0);
`else
    assign flush_pend = 1'b0;
`endif

    // A pending flush also holds off non-completing words so none slip in mid-flush.
    assign rdy_upward = !((phase == PH_LAST) && slot_blocked) &&
                        !(flush_pend && (phase == PH_FILL));
    assign in_fire    = vld_in && rdy_upward;
    assign out_fire   = vld_q && rdy_downward;
    assign flush_take = flush_pend && !slot_blocked && !(in_fire && (phase == PH_LAST));

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        dout_d = dout_q;
        vld_d  = vld_q;
        if (clr) begin
            cnt_d  = '0;
            acc_d  = '0;
            dout_d = '0;
            vld_d  = 1'b0;
        end else if (in_fire && (phase == PH_LAST)) begin
            dout_d = {din, acc_q};
            vld_d  = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
        end else if (flush_take) begin
            dout_d = {{IN_WIDTH{1'b0}}, acc_q};
            vld_d  = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
        end else begin
            if (out_fire) begin
                vld_d = 1'b0;
            end
            if (in_fire) begin
                acc_d[cnt_q[CNT_W-2:0]] = din;
                cnt_d                   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
        end
    end

    assign dout    = dout_q;
    assign vld_out = vld_q;

endmodule

// File: tb/tb_read_queue.sv
// Scoreboard bench for read_queue: expected beats are queued as words are driven.
module tb_read_queue;

    localparam int IW   = 32;
    localparam int OW   = 512;
    localparam int MAXW = OW / IW;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] din;
    logic          vld_in;
    logic          rdy_upward;
    logic [OW-1:0] dout;
    logic          vld_out;
    logic          rdy_downward;
    logic          ap_start;
`ifdef READ_QUEUE_FLUSH_EN
    logic          flush;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int beats = 0;
    logic [OW-1:0] sb[$];
    int            beat_cyc[$];
    logic [OW-1:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    read_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .vld_in       (vld_in),
        .rdy_upward   (rdy_upward),
        .dout         (dout),
        .vld_out      (vld_out),
        .rdy_downward (rdy_downward),
        .ap_start     (ap_start)
`ifdef READ_QUEUE_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    // Output-side scoreboard: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && vld_out && rdy_downward) begin
            tests++;
            beats++;
            beat_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected got=%h required=none", dout);
            end else begin
                mon_exp = sb.pop_front();
                if (dout !== mon_exp) begin
                    fails++;
                    $display("FAIL beat_data got=%h required=%h", dout, mon_exp);
                end
            end
        end
    end

    function automatic logic [OW-1:0] make_beat(input logic [IW-1:0] base);
        logic [OW-1:0] b;
        b = '0;
        for (int i = 0; i < MAXW; i++) b[i*IW +: IW] = base + IW'(i);
        return b;
    endfunction

    task automatic send_word(input logic [IW-1:0] w, output int stalls);
        stalls = 0;
        din    = w;
        vld_in = 1'b1;
        @(negedge clk);
        while (!rdy_upward && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!rdy_upward) begin
            tests++;
            fails++;
            $display("FAIL send_timeout got=rdy_upward=0 required=1 word=%h", w);
        end
        @(posedge clk);
        #1;
        vld_in = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        din          = '0;
        vld_in       = 1'b0;
        rdy_downward = 1'b0;
        ap_start     = 1'b0;
`ifdef READ_QUEUE_FLUSH_EN
        flush        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (vld_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_vld_out got=%b required=0", vld_out);
        end
        tests++;
        if (dout !== '0) begin
            fails++;
            $display("FAIL reset_dout got=%h required=0", dout);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (rdy_upward !== 1'b1) begin
            fails++;
            $display("FAIL reset_rdy_upward got=%b required=1", rdy_upward);
        end
    endtask

    task automatic test_single_beat();
        int st;
        int total;
        total        = 0;
        rdy_downward = 1'b1;
        sb.push_back(make_beat(32'h0));
        for (int i = 0; i < MAXW; i++) begin
            send_word(IW'(i), st);
            total += st;
        end
        tests++;
        if (vld_out !== 1'b1) begin
            fails++;
            $display("FAIL single_latency got=vld_out=%b required=1", vld_out);
        end
        tests++;
        if (dout[31:0] !== 32'h0) begin
            fails++;
            $display("FAIL single_word0 got=%h required=0", dout[31:0]);
        end
        tests++;
        if (dout[511:480] !== 32'hF) begin
            fails++;
            $display("FAIL single_word15 got=%h required=f", dout[511:480]);
        end
        tests++;
        if (total !== 0) begin
            fails++;
            $display("FAIL single_stalls got=%0d required=0", total);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (vld_out !== 1'b0) begin
            fails++;
            $display("FAIL single_drain got=vld_out=%b required=0", vld_out);
        end
    endtask

    task automatic test_continuous();
        int st;
        int total;
        int b0;
        total = 0;
        b0    = beats;
        beat_cyc.delete();
        rdy_downward = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(make_beat(IW'(32'h1000 + 16 * k)));
        for (int i = 0; i < 3 * MAXW; i++) begin
            send_word(IW'(32'h1000 + i), st);
            total += st;
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (beats - b0 !== 3) begin
            fails++;
            $display("FAIL cont_beats got=%0d required=3", beats - b0);
        end
        tests++;
        if (total !== 0) begin
            fails++;
            $display("FAIL cont_stalls got=%0d required=0", total);
        end
        if (beat_cyc.size() == 3) begin
            tests++;
            if ((beat_cyc[1] - beat_cyc[0] !== MAXW) || (beat_cyc[2] - beat_cyc[1] !== MAXW)) begin
                fails++;
                $display("FAIL cont_spacing got=%0d,%0d required=%0d", beat_cyc[1] - beat_cyc[0],
                         beat_cyc[2] - beat_cyc[1], MAXW);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st;
        int total;
        logic [OW-1:0] beat_a;
        logic [OW-1:0] beat_b;
        total        = 0;
        beat_a       = make_beat(32'h2000);
        beat_b       = make_beat(32'h2010);
        rdy_downward = 1'b0;
        sb.push_back(beat_a);
        for (int i = 0; i < MAXW; i++) begin
            send_word(IW'(32'h2000 + i), st);
            total += st;
        end
        for (int i = 0; i < MAXW - 1; i++) begin
            send_word(IW'(32'h2010 + i), st);
            total += st;
        end
        tests++;
        if (total !== 0) begin
            fails++;
            $display("FAIL bp_fill_stalls got=%0d required=0", total);
        end
        din    = 32'h201F;
        vld_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (rdy_upward !== 1'b0 || vld_out !== 1'b1 || dout !== beat_a) begin
                fails++;
                $display("FAIL bp_hold got=rdy=%b vld=%b word0=%h required=rdy=0 vld=1 word0=%h",
                         rdy_upward, vld_out, dout[31:0], beat_a[31:0]);
            end
        end
        @(posedge clk);
        #1;
        sb.push_back(beat_b);
        rdy_downward = 1'b1;
        @(negedge clk);
        tests++;
        if (rdy_upward !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_rdy got=%b required=1", rdy_upward);
        end
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        tests++;
        if (vld_out !== 1'b1 || dout !== beat_b) begin
            fails++;
            $display("FAIL bp_no_bubble got=vld=%b word15=%h required=vld=1 word15=%h",
                     vld_out, dout[511:480], beat_b[511:480]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_ap_start();
        int st;
        int b0;
        rdy_downward = 1'b1;
        for (int i = 0; i < 7; i++) send_word(IW'(32'h3000 + i), st);
        ap_start = 1'b1;
        din      = 32'hDEAD;
        vld_in   = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        tests++;
        if (vld_out !== 1'b0) begin
            fails++;
            $display("FAIL start_clear_vld got=%b required=0", vld_out);
        end
        b0 = beats;
        sb.push_back(make_beat(32'h3100));
        for (int i = 0; i < MAXW; i++) send_word(IW'(32'h3100 + i), st);
        repeat (3) @(posedge clk);
        #1;
        ap_start = 1'b0;
        tests++;
        if (beats - b0 !== 1) begin
            fails++;
            $display("FAIL start_beats got=%0d required=1", beats - b0);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        int b0;
        rdy_downward = 1'b0;
        for (int i = 0; i < MAXW + 3; i++) send_word(IW'(32'h4000 + i), st);
        reset = 1'b0;
        #1;
        tests++;
        if (vld_out !== 1'b0 || dout !== '0) begin
            fails++;
            $display("FAIL reset_mid_async got=vld=%b word0=%h required=vld=0 dout=0",
                     vld_out, dout[31:0]);
        end
        @(negedge clk);
        reset        = 1'b1;
        rdy_downward = 1'b1;
        @(posedge clk);
        #1;
        b0 = beats;
        sb.push_back(make_beat(32'h5000));
        for (int i = 0; i < MAXW; i++) send_word(IW'(32'h5000 + i), st);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (beats - b0 !== 1) begin
            fails++;
            $display("FAIL reset_mid_clean got=%0d beats required=1", beats - b0);
        end
    endtask

`ifdef READ_QUEUE_FLUSH_EN
    task automatic test_flush();
        int st;
        logic [OW-1:0] exp;
        exp          = '0;
        rdy_downward = 1'b1;
        for (int i = 0; i < 5; i++) exp[i*IW +: IW] = IW'(32'hA1 + i);
        sb.push_back(exp);
        for (int i = 0; i < 5; i++) send_word(IW'(32'hA1 + i), st);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        tests++;
        if (vld_out !== 1'b1) begin
            fails++;
            $display("FAIL flush_vld got=%b required=1", vld_out);
        end
        sb.push_back(make_beat(32'h6000));
        for (int i = 0; i < MAXW; i++) send_word(IW'(32'h6000 + i), st);
        repeat (3) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_continuous();
        test_back_to_back();
        test_ap_start();
        test_reset_mid();
`ifdef READ_QUEUE_FLUSH_EN
        test_flush();
`endif
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
